// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the load path: access-size encodings and the
// byte-offset width derived from the datapath width.
package cpu_mem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  // Number of address bits that select a byte within one datapath word.
  function automatic int off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/mem_data_skid_reg_load_aligner.sv
// Load aligner: shifts the addressed lane of a raw memory word down to bit 0,
// then sign- or zero-extends it. Misaligned or illegal accesses return 0 and
// raise the misaligned flag.
module load_aligner
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]        in_data,
  input  logic [off_w(DATA_W)-1:0] in_addr_lo,
  input  logic [1:0]               in_size,
  input  logic                     in_signed,
  output logic [DATA_W-1:0]        aligned_data,
  output logic                     misaligned
);

  localparam logic [DATA_W-1:0] ONES = '1;

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] ext;
  logic              sign_bit;

  // Select the lane, build its width mask and extend from the lane MSB.
  always_comb begin
    shifted    = in_data >> {in_addr_lo, 3'b000};
    mask       = '0;
    sign_bit   = 1'b0;
    misaligned = 1'b0;
    case (in_size)
      SZ_BYTE: begin
        mask     = ONES >> (DATA_W - 8);
        sign_bit = shifted[7];
      end
      SZ_HALF: begin
        mask       = ONES >> (DATA_W - 16);
        sign_bit   = shifted[15];
        misaligned = in_addr_lo[0];
      end
      SZ_WORD: begin
        mask       = ONES >> (DATA_W - 32);
        sign_bit   = shifted[31];
        misaligned = |in_addr_lo[1:0];
      end
      default: begin
        // A dword only exists on a 64-bit datapath and must be fully aligned.
        mask       = ONES;
        sign_bit   = shifted[DATA_W-1];
        misaligned = (DATA_W != 64) || (|in_addr_lo);
      end
    endcase
    ext = shifted & mask;
    if (in_signed && sign_bit) begin
      ext = ext | ~mask;
    end
    aligned_data = misaligned ? '0 : ext;
  end

endmodule

// File: rtl/mem_data_skid_reg.sv
// Memory-data skid register: aligns returned load data on the push side and
// buffers results in a small FIFO so writeback can stall without losing data.
// Occupancy (empty / partial / full) is carried entirely by count.
module mem_data_skid_reg
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [off_w(DATA_W)-1:0] in_addr_lo,
  input  logic [1:0]               in_size,
  input  logic                     in_signed,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_misaligned,
  output logic [CNT_W-1:0]         count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic              mem_mis  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] aligned_data;
  logic              aligned_mis;
  logic              push;
  logic              pop;

  load_aligner #(.DATA_W(DATA_W)) u_aligner (
    .in_data      (in_data),
    .in_addr_lo   (in_addr_lo),
    .in_size      (in_size),
    .in_signed    (in_signed),
    .aligned_data (aligned_data),
    .misaligned   (aligned_mis)
  );

  // Handshake qualifiers; ready depends only on registered occupancy.
  always_comb begin
    in_ready       = (count < CNT_W'(DEPTH));
    out_valid      = (count != '0);
    push           = in_valid && in_ready;
    pop            = out_valid && out_ready;
    out_data       = out_valid ? mem_data[rd_ptr] : '0;
    out_misaligned = out_valid ? mem_mis[rd_ptr] : 1'b0;
  end

  // Pointer and occupancy update; flush overrides any same-cycle push/pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; cleared only by reset, written with the aligned result.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_mis[i]  <= 1'b0;
      end
    end else if (push && !flush) begin
      mem_data[wr_ptr] <= aligned_data;
      mem_mis[wr_ptr]  <= aligned_mis;
    end
  end

endmodule

// File: tb/tb_mem_data_skid_reg.sv
// Directed self-checking bench for mem_data_skid_reg (DATA_W=32, DEPTH=2).
module tb_mem_data_skid_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_addr_lo;
  logic [1:0]  in_size;
  logic        in_signed;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_misaligned;
  logic [1:0]  count;

  int errors = 0;
  int checks = 0;

  mem_data_skid_reg #(.DATA_W(32), .DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_addr_lo     (in_addr_lo),
    .in_size        (in_size),
    .in_signed      (in_signed),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_misaligned (out_misaligned),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic v, input logic [31:0] d,
                           input logic m, input logic [1:0] c);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".out_data"}, 64'(out_data), 64'(d));
    chk({tag, ".out_misaligned"}, 64'(out_misaligned), 64'(m));
    chk({tag, ".count"}, 64'(count), 64'(c));
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [1:0] a,
                       input logic [1:0] s, input logic sg);
    in_valid   = v;
    in_data    = d;
    in_addr_lo = a;
    in_size    = s;
    in_signed  = sg;
  endtask

  // Push one load into an empty buffer, check the head, then drain it.
  task automatic push_check(input string tag, input logic [31:0] d, input logic [1:0] a,
                            input logic [1:0] s, input logic sg,
                            input logic [31:0] exp_d, input logic exp_m);
    out_ready = 1'b0;
    drive(1'b1, d, a, s, sg);
    tick();
    chk_state(tag, 1'b1, exp_d, exp_m, 2'd1);
    drive(1'b0, 32'hDEAD_BEEF, 2'd0, 2'd2, 1'b0);
    out_ready = 1'b1;
    tick();
    chk({tag, ".drained"}, 64'(count), 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 2'd0, 2'd0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk_state("reset", 1'b0, 32'h0, 1'b0, 2'd0);
    chk("reset.in_ready", 64'(in_ready), 64'd1);

    // Signed byte at offset 3, then unsigned version while popping the first.
    drive(1'b1, 32'h80FF_7F01, 2'd3, 2'd0, 1'b1);
    tick();
    chk_state("byte_s", 1'b1, 32'hFFFF_FF80, 1'b0, 2'd1);
    drive(1'b1, 32'h80FF_7F01, 2'd3, 2'd0, 1'b0);
    out_ready = 1'b1;
    tick();
    chk_state("byte_u", 1'b1, 32'h0000_0080, 1'b0, 2'd1);
    drive(1'b0, 32'h0, 2'd0, 2'd0, 1'b0);
    tick();
    chk_state("byte_drain", 1'b0, 32'h0, 1'b0, 2'd0);
    out_ready = 1'b0;

    push_check("half_mis",  32'h1234_5678, 2'd1, 2'd1, 1'b0, 32'h0000_0000, 1'b1);
    push_check("half_s2",   32'hABCD_1234, 2'd2, 2'd1, 1'b1, 32'hFFFF_ABCD, 1'b0);
    push_check("half_u2",   32'hABCD_1234, 2'd2, 2'd1, 1'b0, 32'h0000_ABCD, 1'b0);
    push_check("byte_s1",   32'h0000_7F00, 2'd1, 2'd0, 1'b1, 32'h0000_007F, 1'b0);
    push_check("word0",     32'hCAFE_F00D, 2'd0, 2'd2, 1'b1, 32'hCAFE_F00D, 1'b0);
    push_check("word_mis",  32'hCAFE_F00D, 2'd2, 2'd2, 1'b0, 32'h0000_0000, 1'b1);
    push_check("dword_ill", 32'hCAFE_F00D, 2'd0, 2'd3, 1'b0, 32'h0000_0000, 1'b1);

    // Fill to DEPTH, attempt a third push while full and popping.
    drive(1'b1, 32'h11, 2'd0, 2'd2, 1'b0);
    tick();
    drive(1'b1, 32'h22, 2'd0, 2'd2, 1'b0);
    tick();
    chk_state("full", 1'b1, 32'h11, 1'b0, 2'd2);
    chk("full.in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h33, 2'd0, 2'd2, 1'b0);
    out_ready = 1'b1;
    chk("full_pop.in_ready", 64'(in_ready), 64'd0);
    tick();
    chk_state("pop_a", 1'b1, 32'h22, 1'b0, 2'd1);
    drive(1'b0, 32'h0, 2'd0, 2'd2, 1'b0);
    tick();
    chk_state("pop_b", 1'b0, 32'h0, 1'b0, 2'd0);

    // Streaming: push and pop every cycle, pointers wrap several times.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(i), 2'd0, 2'd2, 1'b0);
      tick();
      chk_state($sformatf("stream%0d", i), 1'b1, 32'(i), 1'b0, 2'd1);
    end
    drive(1'b0, 32'h0, 2'd0, 2'd2, 1'b0);
    tick();
    chk_state("stream_end", 1'b0, 32'h0, 1'b0, 2'd0);

    // Flush with two buffered entries and a concurrent push.
    out_ready = 1'b0;
    drive(1'b1, 32'hA1, 2'd0, 2'd2, 1'b0);
    tick();
    drive(1'b1, 32'hA2, 2'd0, 2'd2, 1'b0);
    tick();
    chk("pre_flush.count", 64'(count), 64'd2);
    flush = 1'b1;
    drive(1'b1, 32'h55, 2'd0, 2'd2, 1'b0);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 2'd0, 2'd2, 1'b0);
    chk_state("flush_full", 1'b0, 32'h0, 1'b0, 2'd0);
    chk("flush_full.in_ready", 64'(in_ready), 64'd1);

    // Flush with one entry while an accepted push is dropped.
    drive(1'b1, 32'hB1, 2'd0, 2'd2, 1'b0);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'h77, 2'd0, 2'd2, 1'b0);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 2'd0, 2'd2, 1'b0);
    chk_state("flush_part", 1'b0, 32'h0, 1'b0, 2'd0);
    tick();
    chk_state("flush_idle", 1'b0, 32'h0, 1'b0, 2'd0);

    // Reset mid-stream.
    drive(1'b1, 32'hC1, 2'd0, 2'd2, 1'b0);
    tick();
    drive(1'b1, 32'hC2, 2'd0, 2'd2, 1'b0);
    tick();
    chk("pre_reset.count", 64'(count), 64'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, 32'h0, 2'd0, 2'd2, 1'b0);
    chk_state("mid_reset", 1'b0, 32'h0, 1'b0, 2'd0);
    chk("mid_reset.in_ready", 64'(in_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_data_skid_reg.md
Name: mem_data_skid_reg

Overview:
Parametrised successor to the CPU's single memory-data register. It captures load data returned by data memory, then aligns and sign/zero-extends sub-word loads. Results sit in a small FIFO with a valid/ready handshake, so the writeback stage can stall without losing returned data. The block sits between data memory read port and the register-file writeback mux.

Parameters:
DATA_W, 32, datapath width in bits; 32 or 64 only
DEPTH, 2, number of buffered entries; power of two, >= 2
CNT_W, $clog2(DEPTH+1), width of occupancy count (derived, not overridden)

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
in_valid  input  1  memory read data valid this cycle
in_ready  output  1  block can accept in_data this cycle
in_data  input  DATA_W  raw memory word
in_addr_lo  input  $clog2(DATA_W/8)  byte offset of load address within word
in_size  input  2  0=byte, 1=half, 2=word, 3=dword (legal only when DATA_W=64)
in_signed  input  1  1=sign-extend, 0=zero-extend
flush  input  1  discard all buffered entries (pipeline squash)
out_valid  output  1  head entry present
out_ready  input  1  consumer accepts head this cycle
out_data  output  DATA_W  aligned, extended load result
out_misaligned  output  1  head entry was a misaligned/illegal access
count  output  CNT_W  current occupancy

Behaviour:
- Reset (clk edge with reset=1): FIFO empty, pointers 0, all storage cleared to 0.
  - Outputs after reset: out_valid=0, out_data=0, out_misaligned=0, count=0, in_ready=1.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count < DEPTH); purely a function of registered count.
  - Full with a same-cycle pop still shows in_ready=0. There is no combinational ready path from out_ready.
- Alignment is combinational on the input side; the aligned result is what is written into storage.
  - Byte: lane = in_data[8*addr_lo +: 8].
  - Half: lane = in_data[8*addr_lo +: 16]; requires addr_lo[0]=0.
  - Word: lane = in_data[8*addr_lo +: 32]; requires addr_lo[1:0]=0.
  - Dword: requires addr_lo=0 and DATA_W=64.
  - Extension: lane is extended to DATA_W, using its MSB if in_signed=1, else zeros.
  - Misaligned or illegal size: stored data=0 and misaligned flag=1.
- Latency: data pushed at edge t is visible on out_* from t+1 (out_valid=1), if the FIFO was empty. There is no same-cycle bypass.
- Ordering is strict FIFO. out_data and out_misaligned show the head entry; both are 0 while out_valid=0.
- Simultaneous push and pop when 0<count<DEPTH: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH and never underflows.
- Flush: at a clk edge with flush=1, count becomes 0 and pointers reset; storage contents are don't-care but out_* read 0.
  - Flush beats any same-cycle push or pop: the pushed data is dropped.
- Priority: reset > flush > push/pop.
- in_data and related inputs are ignored when in_valid=0.
- out_ready is ignored when out_valid=0.
- No state machine beyond the FIFO occupancy (EMPTY / PARTIAL / FULL derived from count).

Decomposition:
- Shared package cpu_mem_pkg holds:
  - size encodings SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2, SZ_DWORD=2'd3
  - function/constant for byte-offset width from DATA_W.
- One natural sub-module: load_aligner.
  - Purely combinational: in_data, in_addr_lo, in_size, in_signed -> aligned data, misaligned.
  - Parametrised by DATA_W; instantiated once on the push side.
- Top level holds the FIFO storage, pointers, count, and flush logic.

Test Plan:
- Reset then idle -> out_valid=0, out_data=0, count=0, in_ready=1.
- Push in_data=32'h80FF_7F01, addr_lo=3, size=byte, signed=1 -> one cycle later out_data=32'hFFFF_FF80, out_misaligned=0; with signed=0 -> 32'h0000_0080.
- Push half at addr_lo=1 (in_data=32'h1234_5678) -> out_data=0, out_misaligned=1.
- DEPTH=2, out_ready=0: push A=32'h11, B=32'h22 -> count=2, in_ready=0, a third push is ignored. Then out_ready=1 -> A then B on consecutive cycles; count goes 2,1,0.
- Steady stream with in_valid=out_ready=1 for 10 words (0..9) -> outputs 0..9 in order, count stays 1 after the first edge, pointers wrap correctly.
- Buffer holds 2 entries; assert flush together with in_valid=1 -> next cycle count=0, out_valid=0, the pushed word never appears. Repeat with reset mid-stream -> same empty state.
